traffic_light_fsm: RTL and testbench

Single-approach traffic-light controller: cycles Red → Green → Yellow → Red, holding each phase for a parameterised number of 1 Hz ticks. It drives one-hot lamp outputs and the seconds remaining in the current phase. The intersection controller instantiates two copies with complementary initial phases: one starts Red, the other starts Green. Because RedTime = GreenTime + YellowTime, the two approaches stay interlocked.

---
 rtl/traffic_light_fsm.sv | 75 +++++++
 tb/tb_traffic_light_fsm.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/traffic_light_fsm.sv
// Single-approach traffic-light controller: Red -> Green -> Yellow -> Red,
// each phase held for a parameterised number of 1 Hz ticks, with a seconds-remaining count.
module traffic_light_fsm #(
  parameter int RedTime    = 30,
  parameter int GreenTime  = 25,
  parameter int YellowTime = 5
) (
  input  logic       clock1Hz,
  input  logic       rst,
  input  logic [1:0] initialState,
  output logic       R,
  output logic       G,
  output logic       Y,
  output logic [7:0] NUM
);

  typedef enum logic [1:0] {
    PH_RED    = 2'b00,
    PH_GREEN  = 2'b01,
    PH_YELLOW = 2'b10,
    PH_BAD    = 2'b11
  } phase_t;

  localparam logic [7:0] RED_T    = 8'(RedTime);
  localparam logic [7:0] GREEN_T  = 8'(GreenTime);
  localparam logic [7:0] YELLOW_T = 8'(YellowTime);

  phase_t     phase, phase_next, load_phase;
  logic [7:0] count, count_next;

  function automatic logic [7:0] phase_time(input phase_t p);
    case (p)
      PH_GREEN:  return GREEN_T;
      PH_YELLOW: return YELLOW_T;
      default:   return RED_T;
    endcase
  endfunction

  always_ff @(posedge clock1Hz) begin
    if (rst) begin
      phase <= load_phase;
      count <= phase_time(load_phase);
    end else begin
      phase <= phase_next;
      count <= count_next;
    end
  end

  always_comb begin
    load_phase = (initialState == 2'b11) ? PH_RED : phase_t'(initialState);
    phase_next = phase;
    count_next = count - 8'd1;
    // A zero count advances like one so the counter can never wrap to 255.
    if (phase == PH_BAD) begin
      phase_next = PH_RED;
      count_next = RED_T;
    end else if (count <= 8'd1) begin
      case (phase)
        PH_RED:    phase_next = PH_GREEN;
        PH_GREEN:  phase_next = PH_YELLOW;
        default:   phase_next = PH_RED;
      endcase
      count_next = phase_time(phase_next);
    end
  end

  // The unreachable 2'b11 code shows Red so exactly one lamp is always lit.
  always_comb begin
    R   = (phase == PH_RED) || (phase == PH_BAD);
    G   = (phase == PH_GREEN);
    Y   = (phase == PH_YELLOW);
    NUM = count;
  end

endmodule

// File: tb/tb_traffic_light_fsm.sv
// Scoreboard bench: stimulus pushes outputs predicted from the position inside
// the full light cycle; a negedge monitor pops and compares against three DUTs.
module tb_traffic_light_fsm;

  logic       clk;
  logic       rst;
  logic [1:0] init_a, init_b;
  logic       ra, ga, ya, rb, gb, yb, rs, gs, ys;
  logic [7:0] num_a, num_b, num_s;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [10:0] ea;
    logic [10:0] eb;
    logic [10:0] es;
    bit          interlock;
  } item_t;

  item_t sbq[$];
  int pos_a = 0, pos_b = 0, pos_s = 0;

  traffic_light_fsm dut_a (
    .clock1Hz(clk), .rst(rst), .initialState(init_a),
    .R(ra), .G(ga), .Y(ya), .NUM(num_a)
  );

  traffic_light_fsm dut_b (
    .clock1Hz(clk), .rst(rst), .initialState(init_b),
    .R(rb), .G(gb), .Y(yb), .NUM(num_b)
  );

  traffic_light_fsm #(.RedTime(1), .GreenTime(2), .YellowTime(1)) dut_s (
    .clock1Hz(clk), .rst(rst), .initialState(init_a),
    .R(rs), .G(gs), .Y(ys), .NUM(num_s)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Offset of a phase's first second within the Red-Green-Yellow cycle.
  function automatic int start_pos(input logic [1:0] init, input int rt, input int gt);
    case (init)
      2'b01:   return rt;
      2'b10:   return rt + gt;
      default: return 0;
    endcase
  endfunction

  function automatic logic [10:0] lamp_num(input int pos, input int rt, input int gt, input int yt);
    if (pos < rt)           return {3'b100, 8'(rt - pos)};
    else if (pos < rt + gt) return {3'b010, 8'(rt + gt - pos)};
    else                    return {3'b001, 8'(rt + gt + yt - pos)};
  endfunction

  function automatic bit invariant_ok(input logic [10:0] v, input int rt, input int gt, input int yt);
    int lim;
    if ($countones(v[10:8]) != 1) return 1'b0;
    lim = v[10] ? rt : (v[9] ? gt : yt);
    return (int'(v[7:0]) >= 1) && (int'(v[7:0]) <= lim);
  endfunction

  task automatic check(input string name, input logic [10:0] got, input logic [10:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic [1:0] ia, input logic [1:0] ib, input bit il);
    item_t it;
    #1;
    rst    = r;
    init_a = ia;
    init_b = ib;
    @(posedge clk);
    if (r) begin
      pos_a = start_pos(ia, 30, 25);
      pos_b = start_pos(ib, 30, 25);
      pos_s = start_pos(ia, 1, 2);
    end else begin
      pos_a = (pos_a + 1) % 60;
      pos_b = (pos_b + 1) % 60;
      pos_s = (pos_s + 1) % 4;
    end
    it.ea        = lamp_num(pos_a, 30, 25, 5);
    it.eb        = lamp_num(pos_b, 30, 25, 5);
    it.es        = lamp_num(pos_s, 1, 2, 1);
    it.interlock = il;
    sbq.push_back(it);
  endtask

  initial begin : monitor
    item_t it;
    forever begin
      @(negedge clk);
      if (sbq.size() > 0) begin
        it = sbq.pop_front();
        check("dut_a", {ra, ga, ya, num_a}, it.ea);
        check("dut_b", {rb, gb, yb, num_b}, it.eb);
        check("dut_s", {rs, gs, ys, num_s}, it.es);
        check("inv_a", 11'(invariant_ok({ra, ga, ya, num_a}, 30, 25, 5)), 11'd1);
        check("inv_s", 11'(invariant_ok({rs, gs, ys, num_s}, 1, 2, 1)), 11'd1);
        if (it.interlock)
          check("interlock_green", 11'(ga & gb), 11'd0);
      end
    end
  end

  initial begin : stimulus
    rst    = 1'b1;
    init_a = 2'b00;
    init_b = 2'b01;

    // Complementary pair: a starts Red, b starts Green, run two full cycles.
    step(1'b1, 2'b00, 2'b01, 1'b1);
    repeat (120) step(1'b0, 2'b00, 2'b01, 1'b1);

    // Reset held in Yellow, then released.
    repeat (5) step(1'b1, 2'b10, 2'b10, 1'b0);
    repeat (6) step(1'b0, 2'b10, 2'b10, 1'b0);

    // Reset one edge while a is mid-Green with NUM=12.
    step(1'b1, 2'b00, 2'b01, 1'b1);
    repeat (43) step(1'b0, 2'b00, 2'b01, 1'b1);
    step(1'b1, 2'b00, 2'b01, 1'b1);
    repeat (3) step(1'b0, 2'b00, 2'b01, 1'b1);

    // Unused encoding loads Red.
    step(1'b1, 2'b11, 2'b11, 1'b0);
    repeat (4) step(1'b0, 2'b11, 2'b11, 1'b0);

    // Random resets and initial phases.
    repeat (600) begin
      logic       r;
      logic [1:0] ia, ib;
      r  = ($urandom_range(0, 19) == 0);
      ia = 2'($urandom_range(0, 3));
      ib = 2'($urandom_range(0, 3));
      step(r, ia, ib, 1'b0);
    end

    repeat (2) @(negedge clk);
    #1;
    check("scoreboard_drained", 11'(sbq.size()), 11'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
